eth_rx_frame_ctrl: RTL and testbench

ETH_RX_FRAME_CTRL -- requirements
Module: eth_rx_frame_ctrl

---
 rtl/eth_rx_frame_ctrl.sv | 148 ++++++++++++++
 tb/tb_eth_rx_frame_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_ctrl.sv
// RMII receive frame controller: preamble/SFD sync, payload forwarding with CRC-32,
// runt/giant/sync/FCS status and good/bad frame statistics.
module eth_rx_frame_ctrl #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_valid,
  input  logic        byte_valid,
  input  logic [7:0]  rx_byte,
  input  logic        rx_enable,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [10:0] frame_len,
  output logic [3:0]  frame_err,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  localparam logic [10:0] LMIN = 11'(MIN_LEN);
  localparam logic [10:0] LMAX = 11'(MAX_LEN);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {IDLE, PREAMBLE, PAYLOAD, DROP, DONE} state_t;

  state_t      r_state, w_state_n;
  logic        r_dv_d, r_pend, r_silent, w_silent_n;
  logic [31:0] r_crc, w_crc_n;
  logic [10:0] r_len, w_len_n, w_len_inc;
  logic [3:0]  r_err, w_err_n, w_fin_err;
  logic        w_rise, w_fwd, w_chk, w_done;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c;
    for (int i = 0; i < 8; i++)
      x = (x[0] ^ d[i]) ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  // An edge landing in the DONE cycle is held in r_pend so IDLE still sees it
  assign w_rise    = (data_valid & ~r_dv_d) | r_pend;
  assign w_len_inc = (r_len == 11'h7FF) ? r_len : r_len + 11'd1;

  always_comb begin
    w_state_n  = r_state;
    w_len_n    = r_len;
    w_crc_n    = r_crc;
    w_err_n    = r_err;
    w_silent_n = r_silent;
    w_fwd      = 1'b0;
    w_chk      = 1'b0;
    case (r_state)
      IDLE: if (w_rise) begin
        w_len_n    = '0;
        w_err_n    = '0;
        w_silent_n = ~rx_enable;
        w_state_n  = rx_enable ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!data_valid) begin
          w_err_n[3] = 1'b1;
          w_state_n  = DONE;
        end else if (byte_valid) begin
          if (rx_byte == 8'hD5) begin
            w_crc_n   = 32'hFFFFFFFF;
            w_len_n   = '0;
            w_state_n = PAYLOAD;
          end else if (rx_byte != 8'h55) begin
            w_err_n[3] = 1'b1;
            w_state_n  = DONE;
          end
        end
      end
      PAYLOAD: begin
        if (byte_valid) begin
          w_len_n = w_len_inc;
          if (r_len == LMAX) begin
            w_err_n[2] = 1'b1;
            w_state_n  = DROP;
          end else begin
            w_fwd   = 1'b1;
            w_crc_n = crc_byte(r_crc, rx_byte);
          end
        end
        if (!data_valid && w_state_n == PAYLOAD) begin
          w_chk     = 1'b1;
          w_state_n = DONE;
        end
      end
      DROP: begin
        if (byte_valid && !r_silent) w_len_n = w_len_inc;
        if (!data_valid) w_state_n = r_silent ? IDLE : DONE;
      end
      DONE:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // FCS and runt only judge frames that ended normally in PAYLOAD
  assign w_done    = (w_state_n == DONE);
  assign w_fin_err = w_err_n | {2'b00, w_chk && (w_len_n < LMIN), w_chk && (w_crc_n != CRC_RESIDUE)};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_dv_d     <= 1'b1;  // a carrier already up at release must not look like a new edge
      r_pend     <= 1'b0;
      r_silent   <= 1'b0;
      r_crc      <= '0;
      r_len      <= '0;
      r_err      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      frame_len  <= '0;
      frame_err  <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      r_state    <= w_state_n;
      r_dv_d     <= data_valid;
      r_pend     <= (r_state == DONE) && data_valid && !r_dv_d;
      r_silent   <= w_silent_n;
      r_crc      <= w_crc_n;
      r_len      <= w_len_n;
      r_err      <= w_err_n;
      out_valid  <= w_fwd;
      out_sof    <= w_fwd && (r_len == 11'd0);
      if (w_fwd) out_data <= rx_byte;
      frame_done <= w_done;
      if (w_done) begin
        frame_ok  <= (w_fin_err == 4'd0);
        frame_len <= w_len_n;
        frame_err <= w_fin_err;
        if (w_fin_err == 4'd0) good_cnt <= good_cnt + 16'd1;
        else                   bad_cnt  <= bad_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Directed bench for eth_rx_frame_ctrl: good/corrupt/runt/giant/sync/disabled frames,
// end-cycle timing, back-to-back edge in DONE, and reset mid-frame.
module tb_eth_rx_frame_ctrl;

  typedef logic [7:0] byte_q_t [$];

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        data_valid = 1'b0, byte_valid = 1'b0, rx_enable = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic [7:0]  out_data;
  logic        out_valid, out_sof, frame_done, frame_ok;
  logic [10:0] frame_len;
  logic [3:0]  frame_err;
  logic [15:0] good_cnt, bad_cnt;

  int n_chk = 0, n_err = 0;
  int cyc = 0, done_cnt = 0, done_cyc = -1, last_cyc = -2, sof_cnt = 0, sof_idx = -1;
  byte_q_t obs;

  eth_rx_frame_ctrl #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk(clk), .resetn(resetn), .data_valid(data_valid), .byte_valid(byte_valid),
    .rx_byte(rx_byte), .rx_enable(rx_enable), .out_data(out_data), .out_valid(out_valid),
    .out_sof(out_sof), .frame_done(frame_done), .frame_ok(frame_ok), .frame_len(frame_len),
    .frame_err(frame_err), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (resetn) begin
    if (out_valid) begin
      if (out_sof) begin sof_cnt <= sof_cnt + 1; sof_idx <= obs.size(); end
      obs.push_back(out_data);
    end
    if (frame_done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
    if (byte_valid && !data_valid) last_cyc <= cyc;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] fcs_of(input byte_q_t q, input int from);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = from; i < q.size(); i++) begin
      c = c ^ {24'h0, q[i]};
      for (int k = 0; k < 8; k++) c = (c >> 1) ^ (32'hEDB88320 & {32{c[0]}});
    end
    return ~c;
  endfunction

  function automatic byte_q_t build(input int npre, input int ndata, input int seed, input bit add_fcs);
    byte_q_t q;
    int s;
    logic [31:0] f;
    for (int i = 0; i < npre; i++) q.push_back(8'h55);
    q.push_back(8'hD5);
    s = q.size();
    for (int i = 0; i < ndata; i++) q.push_back(8'((i * 37 + seed) & 255));
    if (add_fcs) begin
      f = fcs_of(q, s);
      q.push_back(f[7:0]); q.push_back(f[15:8]); q.push_back(f[23:16]); q.push_back(f[31:24]);
    end
    return q;
  endfunction

  function automatic byte_q_t after_sfd(input byte_q_t q, input int maxn);
    byte_q_t r;
    int s;
    s = 0;
    while (q[s] != 8'hD5) s++;
    for (int i = s + 1; i < q.size() && r.size() < maxn; i++) r.push_back(q[i]);
    return r;
  endfunction

  task automatic clear_mon();
    obs.delete(); sof_cnt = 0; sof_idx = -1; done_cnt = 0;
  endtask

  task automatic feed(input byte_q_t q, input bit coinc);
    for (int i = 0; i < q.size(); i++) begin
      rx_byte = q[i]; byte_valid = 1'b1;
      if (coinc && i == q.size() - 1) data_valid = 1'b0;
      tick();
      byte_valid = 1'b0;
      tick();
    end
    data_valid = 1'b0;
    tick();
  endtask

  task automatic run_frame(input byte_q_t q, input bit coinc);
    clear_mon();
    data_valid = 1'b1; byte_valid = 1'b0;
    tick(); tick();
    feed(q, coinc);
    repeat (4) tick();
  endtask

  task automatic cmp_obs(input string tag, input byte_q_t e);
    int bad;
    bad = 0;
    chk({tag, "_count"}, obs.size(), e.size());
    for (int i = 0; i < obs.size() && i < e.size(); i++) if (obs[i] !== e[i]) bad++;
    chk({tag, "_data"}, bad, 0);
  endtask

  byte_q_t fr, fr2;

  initial begin
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_status", {frame_ok, frame_len, frame_err}, 0);
    chk("rst_cnts", {good_cnt, bad_cnt}, 0);

    // Good 64-byte frame
    fr = build(7, 60, 3, 1'b1);
    run_frame(fr, 1'b0);
    cmp_obs("good", after_sfd(fr, 9999));
    chk("good_sof_cnt", sof_cnt, 1);
    chk("good_sof_first", sof_idx, 0);
    chk("good_done_cnt", done_cnt, 1);
    chk("good_ok", frame_ok, 1);
    chk("good_len", frame_len, 64);
    chk("good_err", frame_err, 4'b0000);
    chk("good_cnt1", good_cnt, 1);

    // Same frame with one payload bit flipped
    fr2 = fr; fr2[18] = fr2[18] ^ 8'h04;
    run_frame(fr2, 1'b0);
    chk("fcs_err", frame_err, 4'b0001);
    chk("fcs_ok", frame_ok, 0);
    chk("fcs_bad_cnt", bad_cnt, 1);

    // Runt: SFD then 16 data + FCS
    fr = build(0, 16, 11, 1'b1);
    run_frame(fr, 1'b0);
    chk("runt_err", frame_err, 4'b0010);
    chk("runt_len", frame_len, 20);
    chk("runt_bad_cnt", bad_cnt, 2);

    // Giant: 1600 bytes after SFD
    fr = build(7, 1600, 5, 1'b0);
    run_frame(fr, 1'b0);
    cmp_obs("giant", after_sfd(fr, 1518));
    chk("giant_err", frame_err, 4'b0100);
    chk("giant_len", frame_len, 1600);
    chk("giant_done_cnt", done_cnt, 1);

    // Sync error in preamble; trailing bytes must not start a new frame
    fr.delete();
    fr.push_back(8'h55); fr.push_back(8'h55); fr.push_back(8'h5A);
    fr.push_back(8'hD5); fr.push_back(8'h11);
    run_frame(fr, 1'b0);
    chk("sync_err", frame_err, 4'b1000);
    chk("sync_len", frame_len, 0);
    chk("sync_done_cnt", done_cnt, 1);
    chk("sync_out", obs.size(), 0);
    chk("sync_bad_cnt", bad_cnt, 4);

    // Receiver disabled: frame silently dropped
    rx_enable = 1'b0;
    run_frame(build(7, 60, 9, 1'b1), 1'b0);
    rx_enable = 1'b1;
    chk("dis_out", obs.size(), 0);
    chk("dis_done_cnt", done_cnt, 0);
    chk("dis_cnts", {good_cnt, bad_cnt}, {16'd1, 16'd4});

    // Last byte coincident with data_valid falling
    fr = build(7, 60, 21, 1'b1);
    run_frame(fr, 1'b1);
    cmp_obs("end", after_sfd(fr, 9999));
    chk("end_done_lat", done_cyc - last_cyc, 1);
    chk("end_len", frame_len, 64);
    chk("end_good_cnt", good_cnt, 2);

    // Carrier loss in preamble, carrier returns during the DONE cycle
    clear_mon();
    data_valid = 1'b1; tick(); tick();
    rx_byte = 8'h55; byte_valid = 1'b1; tick(); byte_valid = 1'b0; tick();
    data_valid = 1'b0; tick();
    data_valid = 1'b1; tick();
    tick();
    fr = build(7, 60, 40, 1'b1);
    feed(fr, 1'b0);
    repeat (4) tick();
    chk("b2b_done_cnt", done_cnt, 2);
    cmp_obs("b2b", after_sfd(fr, 9999));
    chk("b2b_cnts", {good_cnt, bad_cnt}, {16'd3, 16'd5});

    // Reset mid-frame while carrier stays up
    clear_mon();
    fr = build(7, 60, 50, 1'b1);
    data_valid = 1'b1; tick(); tick();
    for (int i = 0; i < 20; i++) begin
      rx_byte = fr[i]; byte_valid = 1'b1; tick(); byte_valid = 1'b0; tick();
    end
    resetn = 1'b0; tick(); resetn = 1'b1;
    clear_mon();
    fr2.delete();
    for (int i = 20; i < fr.size(); i++) fr2.push_back(fr[i]);
    feed(fr2, 1'b0);
    repeat (4) tick();
    chk("rmid_out", obs.size(), 0);
    chk("rmid_done_cnt", done_cnt, 0);
    chk("rmid_cnts", {good_cnt, bad_cnt}, 0);
    run_frame(fr, 1'b0);
    chk("rmid_after_good", good_cnt, 1);
    chk("rmid_after_ok", frame_ok, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
